// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared opcodes, default datapath width and FSM states for the ALU arbiter
package alu_arbiter_pkg;
  localparam int DATA_W_DEF = 64;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_CPZ = 4'b0111;
  typedef enum logic {IDLE, FULL} state_e;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational integer ALU; undefined opcodes yield zero
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);
  always_comb begin
    result = op == OP_AND ? a & b :
             op == OP_ORR ? a | b :
             op == OP_ADD ? a + b :
             op == OP_SUB ? a - b :
             op == OP_CPZ ? b : '0;
    zero = ~|result;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin two-port front end to one shared ALU with a
// single registered result slot returned over per-port valid/ready channels
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero
);
  state_e            state_q, state_d;
  logic              owner_q, owner_d, last_q, last_d, zero_q, zero_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              grant, owner_ready, can_accept, accept, alu_zero;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;
  logic [3:0]        alu_op;
  // Contention goes to the port not granted last; a lone requester always wins.
  always_comb begin
    grant = (req0_valid & req1_valid) ? ~last_q : (req1_valid & ~req0_valid);
    owner_ready = owner_q ? rsp1_ready : rsp0_ready;
    can_accept = (state_q == IDLE) | owner_ready;
    accept = can_accept & (req0_valid | req1_valid);
    alu_a = grant ? req1_a : req0_a;
    alu_b = grant ? req1_b : req0_b;
    alu_op = grant ? req1_op : req0_op;
  end
  alu_arbiter_alu #(.DATA_W(DATA_W)) u_alu (
    .a(alu_a),
    .b(alu_b),
    .op(alu_op),
    .result(alu_y),
    .zero(alu_zero)
  );
  always_comb begin
    state_d = accept ? FULL : owner_ready ? IDLE : state_q;
    owner_d = accept ? grant : owner_q;
    last_d = accept ? grant : last_q;
    result_d = accept ? alu_y : result_q;
    zero_d = accept ? alu_zero : zero_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q <= 1'b1;
      result_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      result_q <= result_d;
      zero_q <= zero_d;
    end
  end
  assign req0_ready = can_accept & req0_valid & ~grant;
  assign req1_ready = can_accept & req1_valid & grant;
  assign rsp0_valid = (state_q == FULL) & ~owner_q;
  assign rsp1_valid = (state_q == FULL) & owner_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero = zero_q;
  assign rsp1_zero = zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed stimulus with a queue scoreboard of expected responses
module tb_alu_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_op = 0, req1_op = 0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
  logic [63:0] rsp0_result, rsp1_result;
  int tests = 0, fails = 0;
  typedef struct {logic port; logic [63:0] res; logic z;} exp_t;
  exp_t sb[$];
  logic pv0 = 0, pr0 = 0, pv1 = 0, pr1 = 0;
  int g;

  alu_arbiter #(.DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input logic port, input logic [63:0] res, input logic z);
    exp_t e;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("sb_port", port, e.port);
      chk("sb_result", res, e.res);
      chk("sb_zero", z, e.z);
    end
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      pv0 = 0; pr0 = 0; pv1 = 0; pr1 = 0;
    end else begin
      if (pv0 && !pr0) chk("no_retract0", req0_valid, 1);
      if (pv1 && !pr1) chk("no_retract1", req1_valid, 1);
      chk("one_grant", req0_ready & req1_ready, 0);
      chk("one_rsp", rsp0_valid & rsp1_valid, 0);
      if (rsp0_valid && rsp0_ready) pop_chk(1'b0, rsp0_result, rsp0_zero);
      if (rsp1_valid && rsp1_ready) pop_chk(1'b1, rsp1_result, rsp1_zero);
      if (req0_ready) sb.push_back('{1'b0, model(req0_a, req0_b, req0_op), model(req0_a, req0_b, req0_op) == 0});
      if (req1_ready) sb.push_back('{1'b1, model(req1_a, req1_b, req1_op), model(req1_a, req1_b, req1_op) == 0});
      pv0 = req0_valid; pr0 = req0_ready; pv1 = req1_valid; pr1 = req1_ready;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  task automatic do_reset();
    rst = 1; sb.delete();
    cyc();
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(); cyc();
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_result", rsp0_result, 0);
    chk("rst_zero", rsp0_zero, 0);
    rst = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    // single ADD
    set0(1, 4'b0010, 5, 7);
    #3 chk("add_req0_ready", req0_ready, 1);
    chk("add_req1_ready", req1_ready, 0);
    cyc(); req0_valid = 0;
    #3 chk("add_rsp0_valid", rsp0_valid, 1);
    chk("add_result", rsp0_result, 12);
    chk("add_zero", rsp0_zero, 0);
    chk("add_rsp1_valid", rsp1_valid, 0);
    cyc();
    // contention right after reset: port 0 first, then alternating
    do_reset();
    set0(1, 4'b0110, 9, 9);
    set1(1, 4'b0000, 64'hF0, 64'h0F);
    g = 0;
    for (int i = 0; i < 6; i++) begin
      #3 chk("alt_req0_ready", req0_ready, g == 0);
      chk("alt_req1_ready", req1_ready, g == 1);
      if (i > 0) begin
        chk("alt_rsp_valid", g == 0 ? rsp1_valid : rsp0_valid, 1);
        chk("alt_result", rsp0_result, 0);
        chk("alt_zero", rsp0_zero, 1);
      end
      cyc(); g ^= 1;
    end
    req1_valid = 0;
    #3 chk("tail_req0_ready", req0_ready, 1);
    cyc(); req0_valid = 0;
    cyc();
    // back-pressure on port 1 with req0 pending
    rsp1_ready = 0;
    set1(1, 4'b0010, 3, 4);
    #3 chk("bp_req1_ready", req1_ready, 1);
    cyc(); req1_valid = 0;
    set0(1, 4'b0001, 64'h10, 64'h01);
    for (int i = 0; i < 3; i++) begin
      #3 chk("bp_req0_ready", req0_ready, 0);
      chk("bp_req1_ready_low", req1_ready, 0);
      chk("bp_rsp1_valid", rsp1_valid, 1);
      chk("bp_rsp1_result", rsp1_result, 7);
      cyc();
    end
    rsp1_ready = 1;
    #3 chk("bp_release_req0_ready", req0_ready, 1);
    cyc(); req0_valid = 0;
    #3 chk("bp_rsp0_valid", rsp0_valid, 1);
    chk("bp_rsp0_result", rsp0_result, 64'h11);
    chk("bp_rsp1_gone", rsp1_valid, 0);
    cyc();
    // streaming with no bubbles
    for (int i = 0; i < 8; i++) begin
      set0(1, 4'b0010, i, 1);
      #3 chk("stream_req0_ready", req0_ready, 1);
      if (i > 0) begin
        chk("stream_rsp0_valid", rsp0_valid, 1);
        chk("stream_result", rsp0_result, i);
      end
      cyc();
    end
    req0_valid = 0;
    #3 chk("stream_last_valid", rsp0_valid, 1);
    chk("stream_last_result", rsp0_result, 8);
    cyc();
    // asynchronous reset while a result is held
    rsp0_ready = 0;
    set0(1, 4'b0010, 1, 1);
    #3 chk("mid_req0_ready", req0_ready, 1);
    cyc(); req0_valid = 0;
    #1 chk("mid_rsp0_valid", rsp0_valid, 1);
    rst = 1;
    #1 chk("mid_rst_drop", rsp0_valid, 0);
    sb.delete();
    cyc(); rst = 0;
    rsp0_ready = 1;
    set0(1, 4'b0111, 3, 0);
    set1(1, 4'b0001, 1, 2);
    #3 chk("post_rst_req0_wins", req0_ready, 1);
    chk("post_rst_req1_wait", req1_ready, 0);
    cyc(); req0_valid = 0;
    #3 chk("cpz_result", rsp0_result, 0);
    chk("cpz_zero", rsp0_zero, 1);
    chk("post_rst_req1_ready", req1_ready, 1);
    cyc(); req1_valid = 0;
    #3 chk("orr_rsp1_valid", rsp1_valid, 1);
    chk("orr_result", rsp1_result, 3);
    chk("orr_zero", rsp1_zero, 0);
    cyc();
    // undefined opcode and SUB wrap
    set0(1, 4'b1111, 5, 5);
    #3 chk("undef_req0_ready", req0_ready, 1);
    cyc(); req0_valid = 0;
    #3 chk("undef_result", rsp0_result, 0);
    chk("undef_zero", rsp0_zero, 1);
    cyc();
    set0(1, 4'b0110, 0, 1);
    #3 chk("sub_req0_ready", req0_ready, 1);
    cyc(); req0_valid = 0;
    #3 chk("sub_result", rsp0_result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub_zero", rsp0_zero, 0);
    cyc(); cyc();
    #3 chk("sb_drained", sb.size(), 0);
    chk("idle_rsp0_valid", rsp0_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
